rr_mux8_arbiter: RTL and testbench
==================================

Name: rr_mux8_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8:1 datapath mux among 8 requesters.
- Each requester raises a request. The block grants exactly one owner and drives the 3-bit select of the 8:1 mux to that owner.
- The selected lane is presented as a single output with a valid flag.
- Sits between 8 producer lanes and one shared downstream consumer.

Parameters:
- W, 1, data width per lane; total input bus width is 8*W.
- MAX_BURST, 4, maximum consecutive grant cycles per owner. Used only when ARB_BURST_LIMIT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request per lane; req[k] is lane k.
- din  input  8*W  lane data; lane k is din[k*W +: W].
- gnt  output  8  one-hot grant, registered.
- sel  output  3  mux select = binary index of the current owner, registered.
- busy  output  1  high while a grant is held, registered.
- dout  output  W  din lane selected by sel when busy, else 0 (combinational from registered sel).
- dout_valid  output  1  equals busy.

Behaviour:
- Reset values (async, rst=1):
  - gnt=8'h00, sel=3'd0, busy=0, dout=0, dout_valid=0.
  - Internal rr pointer ptr=3'd0, burst counter cnt=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: the first set bit scanning ptr, ptr+1, ... modulo 8, with wrap 7->0.
  - On that edge: gnt=onehot(winner), sel=winner, busy=1, ptr=winner+1 mod 8, cnt=0, and move to GRANT.
  - Latency: req sampled at edge N gives gnt visible after edge N.
- GRANT, owner still requesting (req[sel]=1): hold gnt/sel; cnt increments, saturating at MAX_BURST-1.
- GRANT, owner drops (req[sel]=0):
  - If other requests are pending, re-arbitrate from ptr on the same edge. The new owner is granted immediately, with no idle bubble.
  - If nothing is pending, go to IDLE with gnt=0 and busy=0.
- Round-robin fairness:
  - ptr always points past the most recent winner.
  - A lane that requests continuously is served within 7 intervening grants.
- Requests from non-owners during GRANT have no effect until re-arbitration.
- A req pulse shorter than one cycle, deasserted before the sampling edge, is never granted.
- gnt is always one-hot or zero, and sel always matches gnt when busy=1.
- Reset mid-grant: all outputs return to reset values immediately (asynchronous). The first arbitration after reset starts from lane 0.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- Defined:
  - When the owner has held the grant for MAX_BURST cycles (cnt==MAX_BURST-1) and (req & ~gnt)!=0, the grant is revoked on the next edge and re-arbitration proceeds from ptr.
  - The previous owner competes again only after ptr wraps around to it.
  - If no other lane is requesting, the owner keeps the grant and cnt stays saturated.
- Not defined: MAX_BURST and cnt are unused and optimised out; the owner holds the grant until it drops req.

Decomposition:
- Shared package/include:
  - State encoding constants ST_IDLE=1'b0 and ST_GRANT=1'b1.
  - Lane count constant NUM_LANES=8.
  - Select width constant SEL_W=3.
- Sub-module mux8_bus: a W-bit parameterised 8:1 combinational mux (din, sel -> y). It is instantiated once for dout, gated by busy.
- The round-robin priority search is a function inside rr_mux8_arbiter, not a separate module.

Test Plan:
- Single lane:
  - Stimulus: rst released, req=8'b0000_0100, din lane2=1.
  - Response: after 1 edge, gnt=8'h04, sel=2, busy=1, dout=1.
  - After req drops, gnt=0 and busy=0 after 1 edge.
- All lanes, round-robin order:
  - Stimulus: req=8'hFF held; each owner drops its req for 1 cycle after 2 grant cycles, then re-asserts.
  - Response: grant order 0,1,2,...,7,0, with no idle cycle between owners.
- Back-to-back handover:
  - Stimulus: lane3 owner, lane5 pending, lane3 drops req.
  - Response: next edge gnt=8'h20, sel=5, busy stays 1.
- Reset mid-grant:
  - Stimulus: assert rst asynchronously while gnt=8'h40.
  - Response: gnt=0, sel=0, busy=0 without waiting for a clock edge.
  - Next arbitration with req=8'hC0 grants lane 6, because ptr=0 scans 0..6.
- ARB_BURST_LIMIT_EN, MAX_BURST=4:
  - Stimulus: req[1] and req[4] held high.
  - Response: lane1 granted for exactly 4 cycles, then lane4 for 4, then lane1 again.
  - With only req[1] high, lane1 holds indefinitely.
- Data path:
  - Stimulus: W=8, din lanes 0..7 set to 8'h10..8'h17, each lane granted in turn.
  - Response: dout equals 8'h10+sel every busy cycle, and dout=0 when idle.

Source files
------------

// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared constants and types for the 8-lane round-robin mux arbiter.
// Optional build macro used by the top: ARB_BURST_LIMIT_EN.
package rr_mux8_arbiter_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    function automatic logic [NUM_LANES-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [NUM_LANES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux8_arbiter_mux8_bus.sv
// W-bit 8:1 combinational mux; lane k occupies i_din[k*W +: W].
module mux8_bus
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [NUM_LANES*W-1:0] i_din,
    input  logic [SEL_W-1:0]       i_sel,
    output logic [W-1:0]           o_y
);

    always_comb begin
        o_y = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_y = i_din[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter owning the select of a shared 8:1 lane mux.
// Define ARB_BURST_LIMIT_EN to revoke a grant after MAX_BURST cycles when others wait.
module rr_mux8_arbiter
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int W         = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_LANES-1:0]   req,
    input  logic [NUM_LANES*W-1:0] din,
    output logic [NUM_LANES-1:0]   gnt,
    output logic [SEL_W-1:0]       sel,
    output logic                   busy,
    output logic [W-1:0]           dout,
    output logic                   dout_valid
);

    // state | meaning
    // IDLE  | no owner, arbitrate from r_ptr whenever any req is set
    // GRANT | lane r_sel owns the mux until it drops req (or its burst expires)

    // First requesting lane at or after ptr_v, wrapping 7->0.
    function automatic pick_t rr_pick(input logic [NUM_LANES-1:0] req_v,
                                      input logic [SEL_W-1:0]     ptr_v);
        pick_t            res;
        logic [SEL_W-1:0] k;
        res = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            k = ptr_v + SEL_W'(i);
            if (req_v[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_LANES-1:0] r_gnt;
    logic [NUM_LANES-1:0] w_gnt_nxt;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic [SEL_W-1:0]     r_ptr;
    logic [SEL_W-1:0]     w_ptr_nxt;
    pick_t                w_pick;
    logic                 w_take;
    logic [SEL_W-1:0]     w_win;
    logic [W-1:0]         w_mux_y;

    assign w_pick = rr_pick(req, r_ptr);

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    pick_t      w_pick_oth;

    // The owner is masked out so a revoked lane only returns once ptr wraps to it.
    assign w_pick_oth = rr_pick(req & ~r_gnt, r_ptr);
`else
    localparam int lp_unused_max_burst = MAX_BURST;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_ptr;
        w_take      = 1'b0;
        w_win       = w_pick.idx;
`ifdef ARB_BURST_LIMIT_EN
        w_cnt_nxt   = r_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                w_take = w_pick.found;
            end
            ST_GRANT: begin
                if (!req[r_sel]) begin
                    if (w_pick.found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                    end
                end
`ifdef ARB_BURST_LIMIT_EN
                else if (r_cnt == CNT_LAST) begin
                    if (w_pick_oth.found) begin
                        w_take = 1'b1;
                        w_win  = w_pick_oth.idx;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_take) begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = onehot8(w_win);
            w_sel_nxt   = w_win;
            w_busy_nxt  = 1'b1;
            w_ptr_nxt   = w_win + SEL_W'(1);
`ifdef ARB_BURST_LIMIT_EN
            w_cnt_nxt   = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    mux8_bus #(
        .W (W)
    ) u_mux8_bus (
        .i_din (din),
        .i_sel (r_sel),
        .o_y   (w_mux_y)
    );

    assign gnt        = r_gnt;
    assign sel        = r_sel;
    assign busy       = r_busy;
    assign dout       = r_busy ? w_mux_y : '0;
    assign dout_valid = r_busy;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench for rr_mux8_arbiter: directed scenarios plus random traffic vs a lane-level model.
module tb_rr_mux8_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic          clk;
    logic          rst;
    logic [7:0]    req;
    logic [8*W-1:0] din;
    logic [7:0]    gnt;
    logic [2:0]    sel;
    logic          busy;
    logic [W-1:0]  dout;
    logic          dout_valid;

    int vectors;
    int miscompares;

    // Reference model: current owner (-1 = none), rr pointer, cycles held.
    int m_owner;
    int m_ptr;
    int m_cnt;

    rr_mux8_arbiter #(.W(W), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .sel        (sel),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    function automatic int m_pick(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (p + i) % 8;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic m_grant(input int w);
        m_owner = w;
        m_ptr   = (w + 1) % 8;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int w;
        if (m_owner < 0) begin
            w = m_pick(r, m_ptr);
            if (w >= 0) m_grant(w);
        end else if (!r[m_owner]) begin
            w = m_pick(r, m_ptr);
            if (w >= 0) m_grant(w);
            else m_owner = -1;
        end else begin
`ifdef ARB_BURST_LIMIT_EN
            logic [7:0] others;
            others = r & ~(8'd1 << m_owner);
            if (m_cnt == MB - 1 && others != 8'd0) m_grant(m_pick(others, m_ptr));
            else if (m_cnt < MB - 1) m_cnt = m_cnt + 1;
`endif
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(req);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        din = '1;
        @(posedge clk);
        #1;
        vectors++;
        if ({gnt, sel, busy, dout, dout_valid} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%h sel=%0d busy=%b dout=%h dv=%b, expected all zero",
                     gnt, sel, busy, dout, dout_valid);
        end
        do_reset();
        tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: gnt=%h busy=%b, expected 00/0", gnt, busy);
        end
    endtask

    task automatic test_single_lane();
        do_reset();
        din = '0;
        din[2*W +: W] = 8'h01;
        req = 8'h04;
        tick();
        vectors++;
        if ({gnt, sel, busy, dout_valid, dout} !== {8'h04, 3'd2, 1'b1, 1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL single_grant: gnt=%h sel=%0d busy=%b dv=%b dout=%h, expected 04/2/1/1/01",
                     gnt, sel, busy, dout_valid, dout);
        end
        req = 8'h00;
        tick();
        vectors++;
        if ({gnt, busy, dout_valid, dout} !== {8'h00, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL single_release: gnt=%h busy=%b dv=%b dout=%h, expected 00/0/0/00",
                     gnt, busy, dout_valid, dout);
        end
        #1 req = 8'h01;
        #2 req = 8'h00;
        tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_ignored: gnt=%h busy=%b, expected 00/0", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        int owner;
        do_reset();
        req = 8'hFF;
        tick();
        for (int g = 0; g <= 8; g++) begin
            owner = g % 8;
            vectors++;
            if (gnt !== (8'd1 << owner) || sel !== 3'(owner) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: gnt=%h sel=%0d busy=%b, expected lane %0d busy 1",
                         g, gnt, sel, busy, owner);
            end
            if (g < 8) begin
                tick();
                vectors++;
                if (gnt !== (8'd1 << owner)) begin
                    miscompares++;
                    $display("FAIL rr_hold[%0d]: gnt=%h, expected %h", g, gnt, 8'd1 << owner);
                end
                req = 8'hFF & ~(8'd1 << owner);
                tick();
                req = 8'hFF;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'h08;
        tick();
        vectors++;
        if (gnt !== 8'h08 || sel !== 3'd3) begin
            miscompares++;
            $display("FAIL b2b_first: gnt=%h sel=%0d, expected 08/3", gnt, sel);
        end
        req = 8'h28;
        tick();
        vectors++;
        if (gnt !== 8'h08) begin
            miscompares++;
            $display("FAIL b2b_nonowner: gnt=%h, expected 08", gnt);
        end
        req = 8'h20;
        tick();
        vectors++;
        if ({gnt, sel, busy} !== {8'h20, 3'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_handover: gnt=%h sel=%0d busy=%b, expected 20/5/1", gnt, sel, busy);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h40;
        tick();
        vectors++;
        if (gnt !== 8'h40) begin
            miscompares++;
            $display("FAIL midrst_pre: gnt=%h, expected 40", gnt);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({gnt, sel, busy, dout_valid} !== 13'd0) begin
            miscompares++;
            $display("FAIL midrst_async: gnt=%h sel=%0d busy=%b dv=%b, expected all zero",
                     gnt, sel, busy, dout_valid);
        end
        req = 8'hC0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        tick();
        vectors++;
        if (gnt !== 8'h40 || sel !== 3'd6) begin
            miscompares++;
            $display("FAIL midrst_ptr: gnt=%h sel=%0d, expected 40/6", gnt, sel);
        end
    endtask

    task automatic test_datapath();
        do_reset();
        for (int k = 0; k < 8; k++) din[k*W +: W] = 8'h10 + 8'(k);
        for (int k = 0; k < 8; k++) begin
            req = 8'd1 << k;
            tick();
            vectors++;
            if (sel !== 3'(k) || dout !== 8'h10 + 8'(k) || dout_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL data_lane[%0d]: sel=%0d dout=%h dv=%b, expected %0d/%h/1",
                         k, sel, dout, dout_valid, k, 8'h10 + 8'(k));
            end
            req = 8'h00;
            tick();
            vectors++;
            if (dout !== 8'h00 || dout_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL data_idle[%0d]: dout=%h dv=%b, expected 00/0", k, dout, dout_valid);
            end
        end
    endtask

`ifdef ARB_BURST_LIMIT_EN
    task automatic test_burst();
        logic [7:0] exp_seq [12];
        do_reset();
        for (int i = 0; i < 12; i++) exp_seq[i] = ((i / MB) % 2 == 0) ? 8'h02 : 8'h10;
        req = 8'h12;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (gnt !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL burst_seq[%0d]: gnt=%h, expected %h", i, gnt, exp_seq[i]);
            end
        end
        do_reset();
        req = 8'h02;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (gnt !== 8'h02) begin
                miscompares++;
                $display("FAIL burst_alone[%0d]: gnt=%h, expected 02", i, gnt);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_gnt;
        logic [7:0] exp_dout;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = req ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) req = 8'h00;
            din = {$urandom, $urandom};
            tick();
            exp_gnt  = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
            exp_dout = (m_owner < 0) ? 8'h00 : din[m_owner*W +: W];
            vectors++;
            if ({gnt, busy, dout_valid, dout} !== {exp_gnt, m_owner >= 0, m_owner >= 0, exp_dout}) begin
                miscompares++;
                $display("FAIL random[%0d]: gnt=%h busy=%b dv=%b dout=%h, expected %h/%b/%b/%h",
                         c, gnt, busy, dout_valid, dout, exp_gnt, m_owner >= 0, m_owner >= 0, exp_dout);
            end
            if (m_owner >= 0) begin
                vectors++;
                if (sel !== 3'(m_owner)) begin
                    miscompares++;
                    $display("FAIL random_sel[%0d]: sel=%0d, expected %0d", c, sel, m_owner);
                end
            end
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        req         = 8'h00;
        din         = '0;
        vectors     = 0;
        miscompares = 0;
        model_reset();

        test_reset();
        test_single_lane();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_grant();
        test_datapath();
`ifdef ARB_BURST_LIMIT_EN
        test_burst();
`endif
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
